// File: rtl/ir_decode_stage.sv
// RV32I decode stage: decodes fields/format/immediate on push into a BUF_DEPTH-entry FIFO.
// Optional illegal-encoding check is enabled by defining IR_DECODE_ILLEGAL_CHK_EN.
module ir_decode_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_ir,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [6:0]                   opcode,
  output logic [4:0]                   rd,
  output logic [2:0]                   funct3,
  output logic [4:0]                   rs1,
  output logic [4:0]                   rs2,
  output logic [6:0]                   funct7,
  output logic [2:0]                   fmt,
  output logic [31:0]                  imm,
  output logic                         illegal,
  output logic [$clog2(BUF_DEPTH):0]   count
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd7
  } fmt_e;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  logic [31:0]         mem_ir  [BUF_DEPTH];
  logic [PC_WIDTH-1:0] mem_pc  [BUF_DEPTH];
  logic [2:0]          mem_fmt [BUF_DEPTH];
  logic [31:0]         mem_imm [BUF_DEPTH];

  logic [6:0]  d_op;
  fmt_e        d_fmt;
  logic [31:0] d_imm;
  logic [31:0] head_ir;

  assign d_op = in_ir[6:0];

  always_comb begin
    d_fmt = FMT_X;
    case (d_op)
      7'b0110011:                                           d_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0001111:                                           d_fmt = FMT_I;
      7'b0100011:                                           d_fmt = FMT_S;
      7'b1100011:                                           d_fmt = FMT_B;
      7'b0110111, 7'b0010111:                               d_fmt = FMT_U;
      7'b1101111:                                           d_fmt = FMT_J;
      default:                                              d_fmt = FMT_X;
    endcase
  end

  always_comb begin
    d_imm = '0;
    case (d_fmt)
      FMT_I:   d_imm = {{20{in_ir[31]}}, in_ir[31:20]};
      FMT_S:   d_imm = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      FMT_B:   d_imm = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
      FMT_U:   d_imm = {in_ir[31:12], 12'b0};
      FMT_J:   d_imm = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
      default: d_imm = '0;
    endcase
  end

  assign in_ready  = (count != CNT_W'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Explicit wrap keeps BUF_DEPTH==1 correct; identical to natural wrap for other powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir[wr_ptr]  <= in_ir;
      mem_pc[wr_ptr]  <= in_pc;
      mem_fmt[wr_ptr] <= d_fmt;
      mem_imm[wr_ptr] <= d_imm;
    end
  end

  assign head_ir = mem_ir[rd_ptr];
  assign out_pc  = mem_pc[rd_ptr];
  assign opcode  = head_ir[6:0];
  assign rd      = head_ir[11:7];
  assign funct3  = head_ir[14:12];
  assign rs1     = head_ir[19:15];
  assign rs2     = head_ir[24:20];
  assign funct7  = head_ir[31:25];
  assign fmt     = mem_fmt[rd_ptr];
  assign imm     = mem_imm[rd_ptr];

`ifdef IR_DECODE_ILLEGAL_CHK_EN
  logic       mem_ill [BUF_DEPTH];
  logic       d_ill;
  logic [2:0] d_f3;
  logic [6:0] d_f7;

  assign d_f3 = in_ir[14:12];
  assign d_f7 = in_ir[31:25];

  always_comb begin
    d_ill = (d_op[1:0] != 2'b11) || (d_fmt == FMT_X);
    case (d_op)
      7'b0110011: begin
        if (d_f7 != 7'b0000000 && d_f7 != 7'b0100000) d_ill = 1'b1;
        else if (d_f7 == 7'b0100000 && d_f3 != 3'b000 && d_f3 != 3'b101) d_ill = 1'b1;
      end
      7'b0000011: if (d_f3 == 3'b011 || d_f3 == 3'b110 || d_f3 == 3'b111) d_ill = 1'b1;
      7'b0100011: if (d_f3 >= 3'b011) d_ill = 1'b1;
      7'b1100011: if (d_f3 == 3'b010 || d_f3 == 3'b011) d_ill = 1'b1;
      7'b1100111: if (d_f3 != 3'b000) d_ill = 1'b1;
      7'b0010011: begin
        if (d_f3 == 3'b001 && d_f7 != 7'b0000000) d_ill = 1'b1;
        else if (d_f3 == 3'b101 && d_f7 != 7'b0000000 && d_f7 != 7'b0100000) d_ill = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_ill[wr_ptr] <= d_ill;
  end

  assign illegal = mem_ill[rd_ptr];
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ir_decode_stage.sv
// Directed bench for ir_decode_stage (default parameters); follows IR_DECODE_ILLEGAL_CHK_EN if defined.
module tb_ir_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [2:0]  fmt;
  logic [31:0] imm;
  logic        illegal;
  logic [1:0]  count;

  int checks = 0;
  int passes = 0;

  ir_decode_stage #(.PC_WIDTH(32), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .fmt(fmt), .imm(imm), .illegal(illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef IR_DECODE_ILLEGAL_CHK_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  logic [31:0] s_ir  [7];
  logic [31:0] s_imm [7];
  logic [2:0]  s_fmt [7];
  logic        s_ill [7];
  logic [31:0] l_ir  [3];
  logic [2:0]  l_fmt [3];
  logic        l_ill [3];

  initial begin
    s_ir[0] = 32'hFFF00093; s_imm[0] = 32'hFFFFFFFF; s_fmt[0] = 3'd1; s_ill[0] = 1'b0;
    s_ir[1] = 32'hFE000EE3; s_imm[1] = 32'hFFFFFFFC; s_fmt[1] = 3'd3; s_ill[1] = 1'b0;
    s_ir[2] = 32'h123452B7; s_imm[2] = 32'h12345000; s_fmt[2] = 3'd4; s_ill[2] = 1'b0;
    s_ir[3] = 32'h0040006F; s_imm[3] = 32'h00000004; s_fmt[3] = 3'd5; s_ill[3] = 1'b0;
    s_ir[4] = 32'hFE20AE23; s_imm[4] = 32'hFFFFFFFC; s_fmt[4] = 3'd2; s_ill[4] = 1'b0;
    s_ir[5] = 32'h0080A283; s_imm[5] = 32'h00000008; s_fmt[5] = 3'd1; s_ill[5] = 1'b0;
    s_ir[6] = 32'h0000007F; s_imm[6] = 32'h00000000; s_fmt[6] = 3'd7; s_ill[6] = ILL_ON;
    l_ir[0] = 32'h00000000; l_fmt[0] = 3'd7; l_ill[0] = ILL_ON;
    l_ir[1] = 32'h40001033; l_fmt[1] = 3'd0; l_ill[1] = ILL_ON;
    l_ir[2] = 32'h40000033; l_fmt[2] = 3'd0; l_ill[2] = 1'b0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_pc = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // add x31,x1,x2
    in_valid = 1'b1; in_ir = 32'h00208FB3; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_opcode", 32'(opcode), 32'h33);
    chk("add_rd", 32'(rd), 32'd31);
    chk("add_rs1", 32'(rs1), 32'd1);
    chk("add_rs2", 32'(rs2), 32'd2);
    chk("add_funct3", 32'(funct3), 32'd0);
    chk("add_funct7", 32'(funct7), 32'd0);
    chk("add_fmt", 32'(fmt), 32'd0);
    chk("add_imm", imm, 32'd0);
    chk("add_pc", out_pc, 32'h100);
    chk("add_illegal", 32'(illegal), 32'd0);
    out_ready = 1'b1;
    step();
    chk("add_pop_count", 32'(count), 32'd0);
    chk("add_pop_valid", 32'(out_valid), 32'd0);

    // Streaming with out_ready=1: each new word becomes head one cycle after push.
    for (int unsigned i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_ir = s_ir[i]; in_pc = 32'h300 + 32'(4 * i);
      step();
      chk($sformatf("strm%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("strm%0d_imm", i), imm, s_imm[i]);
      chk($sformatf("strm%0d_fmt", i), 32'(fmt), 32'(s_fmt[i]));
      chk($sformatf("strm%0d_pc", i), out_pc, 32'h300 + 32'(4 * i));
      chk($sformatf("strm%0d_ill", i), 32'(illegal), 32'(s_ill[i]));
      chk($sformatf("strm%0d_count", i), 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain_count", 32'(count), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h00100093; in_pc = 32'h200;
    step();
    in_ir = 32'h00200113; in_pc = 32'h204;
    step();
    chk("bp_full_count", 32'(count), 32'd2);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_ir = 32'h00300193; in_pc = 32'h208;
    step();
    chk("bp_reject_count", 32'(count), 32'd2);
    chk("bp_head_pc", out_pc, 32'h200);
    chk("bp_head_imm", imm, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_pop_count", 32'(count), 32'd1);
    chk("bp_pop_in_ready", 32'(in_ready), 32'd1);
    chk("bp_second_pc", out_pc, 32'h204);
    chk("bp_second_imm", imm, 32'd2);

    // Simultaneous push and pop at count 1; rejected word must never appear.
    in_valid = 1'b1; in_ir = 32'h00400213; in_pc = 32'h20C; out_ready = 1'b1;
    step();
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_head_pc", out_pc, 32'h20C);
    chk("pp_head_imm", imm, 32'd4);

    // Flush with count 2 and an offered word
    out_ready = 1'b0; in_ir = 32'h00500293; in_pc = 32'h210;
    step();
    chk("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1; in_ir = 32'h00600313; in_pc = 32'h214; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("fl_dropped_count", 32'(count), 32'd0);
    in_valid = 1'b1; in_ir = 32'h00700393; in_pc = 32'h218;
    step();
    in_valid = 1'b0;
    chk("fl_after_pc", out_pc, 32'h218);
    chk("fl_after_imm", imm, 32'd7);
    chk("fl_after_count", 32'(count), 32'd1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Illegal-encoding vectors
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ir = l_ir[i]; in_pc = 32'h400 + 32'(4 * i);
      step();
      chk($sformatf("ill%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("ill%0d_fmt", i), 32'(fmt), 32'(l_fmt[i]));
      chk($sformatf("ill%0d_flag", i), 32'(illegal), 32'(l_ill[i]));
    end
    in_valid = 1'b0;
    step();
    chk("end_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ir_decode_stage.md
# ir_decode_stage

Registered RV32I instruction-decode stage with a parametrised elastic buffer, between instruction fetch and register read/execute. Each accepted instruction word (with its PC) is decoded on push into opcode/register/funct fields, instruction format, and the fully assembled sign-extended immediate. The results are held in a BUF_DEPTH-entry FIFO. Valid/ready handshakes on both sides and a synchronous flush support pipeline stalls and branch redirects.

## Interface
- PC_WIDTH, 32, width of the PC carried alongside each instruction
- BUF_DEPTH, 2, FIFO entries; power of two, ≥1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; equals !full
- in_ir  in  32  instruction word
- in_pc  in  PC_WIDTH  instruction address
- out_valid  out  1  head entry is valid
- out_ready  in  1  downstream consumes the head entry
- out_pc  out  PC_WIDTH  PC of the head entry
- opcode  out  7  ir[6:0]
- rd  out  5  ir[11:7]
- funct3  out  3  ir[14:12]
- rs1  out  5  ir[19:15]
- rs2  out  5  ir[24:20]
- funct7  out  7  ir[31:25]
- fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 unknown
- imm  out  32  sign-extended immediate; 0 for R/unknown
- illegal  out  1  head entry is an illegal encoding
- count  out  $clog2(BUF_DEPTH)+1  entries held

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready. Both may occur in the same cycle; count is then unchanged.
- Decode is combinational on in_ir, and the result is written into the FIFO entry on push. Head outputs come directly from storage.
- Format by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → 7
- Immediate assembly, all sign-extended from ir[31]:
  - I: ir[31:20]
  - S: {ir[31:25], ir[11:7]}
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}
  - U: {ir[31:12], 12'b0}, no extension
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}
- Pointers are log2(BUF_DEPTH)-bit and wrap naturally. Full is count==BUF_DEPTH; empty is count==0.
- When out_valid=0, head field outputs are don't-care; the bench must not check them.
- flush: on the next edge count becomes 0 and pointers reset. Flush overrides a push and a pop in the same cycle, and the offered instruction is dropped.

## Timing
- Reset values: out_valid 0, count 0, in_ready 1, all pointers 0. Storage is not reset.
- Latency is 1 cycle. An instruction pushed at edge N appears with out_valid=1 after edge N.
- No combinational path from out_ready to in_ready; in_ready depends only on count.
- A pop from a full buffer raises in_ready the cycle after that edge.
- Reset mid-operation empties the buffer immediately, asynchronously.

## Configuration
- IR_DECODE_ILLEGAL_CHK_EN defined → illegal is computed on push and stored per entry. It is set for any of the following:
  - opcode[1:0]≠11, or fmt==7
  - R-type with funct7 other than 0000000/0100000, or with 0100000 and funct3 not 000 or 101
  - load with funct3 011, 110 or 111
  - store with funct3 ≥011
  - branch with funct3 010 or 011
  - JALR with funct3≠000
  - shift-immediate (funct3 001/101) with an illegal funct7
- IR_DECODE_ILLEGAL_CHK_EN undefined → illegal is tied to 0 and no storage bit is used.

## Test plan
- Reset, then push 0x00208FB3 (add x31,x1,x2) at PC 0x100. One cycle later expect:
  - out_valid=1, opcode 0110011
  - rd 31, rs1 1, rs2 2, funct3 0, funct7 0
  - fmt 0, imm 0, out_pc 0x100
- Push 0xFFF00093, 0xFE000EE3, 0x123452B7, 0x0040006F back to back with out_ready=1. Expect in order:
  - I: imm 0xFFFFFFFF
  - B: imm 0xFFFFFFFC
  - U: imm 0x12345000
  - J: imm 0x00000004
- Backpressure with BUF_DEPTH=2 and out_ready=0:
  - two pushes → count 2, in_ready 0
  - third in_valid is not accepted
  - raise out_ready for one cycle → in_ready returns to 1
  - entries pop in FIFO order
- Simultaneous push and pop at count 1 → count stays 1, order preserved.
- flush asserted with count 2 and in_valid=1 → next cycle count 0, out_valid 0, offered word discarded.
- With IR_DECODE_ILLEGAL_CHK_EN:
  - push 0x00000000 → illegal 1
  - push 0x40001033 (sub funct7, funct3 001) → illegal 1
  - push 0x40000033 → illegal 0
- Without the macro, illegal is always 0.
